// File: rtl/sc2bin_array_ctrl.sv
// rtl/sc2bin_array_ctrl.sv - sequencer for an sc2bin array: clear, count, activate, settle, drain
module sc2bin_array_ctrl #(
    parameter int ROW      = 3,
    parameter int LEN_W    = 10,
    parameter int MAX_SHFT = 4,
    parameter int ACT_LAT  = 1,
    localparam int SW      = $clog2(MAX_SHFT + 1),
    localparam int RW      = (ROW > 1) ? $clog2(ROW) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [SW-1:0]    cfg_shft,
    input  logic [ROW-1:0]   cfg_row_mask,
    output logic             clr,
    output logic             cnt_en,
    output logic             act_en,
    output logic             reg_push,
    output logic [SW-1:0]    shft_amt,
    output logic [ROW-1:0]   row_mask,
    output logic             busy,
    output logic             out_valid,
    output logic             done,
    output logic [RW-1:0]    out_row
);

    localparam int LTW = (ACT_LAT > 1) ? $clog2(ACT_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_COUNT  = 3'd2,
        S_ACT    = 3'd3,
        S_SETTLE = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LTW-1:0]     lat_q, lat_d;
    logic [RW-1:0]      out_row_q, out_row_d;
    logic [SW-1:0]      shft_amt_q, shft_amt_d;
    logic [ROW-1:0]     row_mask_q, row_mask_d;
    logic               clr_q, clr_d;
    logic               cnt_en_q, cnt_en_d;
    logic               act_en_q, act_en_d;
    logic               reg_push_q, reg_push_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;

    // State and datapath registers; reset lands everything at zero / IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            lat_q      <= '0;
            out_row_q  <= '0;
            shft_amt_q <= '0;
            row_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            lat_q      <= lat_d;
            out_row_q  <= out_row_d;
            shft_amt_q <= shft_amt_d;
            row_mask_q <= row_mask_d;
        end
    end

    // Next-state and counter logic; abort overrides every transition
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        lat_d      = lat_q;
        out_row_d  = out_row_q;
        shft_amt_d = shft_amt_q;
        row_mask_d = row_mask_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d    = S_CLR;
                    len_d      = cfg_len;
                    shft_amt_d = (cfg_shft > SW'(MAX_SHFT)) ? SW'(MAX_SHFT) : cfg_shft;
                    row_mask_d = cfg_row_mask;
                end
            end
            S_CLR: begin
                state_d = (len_q != '0) ? S_COUNT : S_ACT;
            end
            S_COUNT: begin
                len_d = len_q - LEN_W'(1);
                if (len_q == LEN_W'(1)) begin
                    state_d = S_ACT;
                end
            end
            S_ACT: begin
                state_d = S_SETTLE;
                lat_d   = LTW'(ACT_LAT - 1);
            end
            S_SETTLE: begin
                if (lat_q == '0) begin
                    state_d   = S_DRAIN;
                    out_row_d = '0;
                end else begin
                    lat_d = lat_q - LTW'(1);
                end
            end
            S_DRAIN: begin
                if (out_row_q == RW'(ROW - 1)) begin
                    state_d   = S_DONE;
                    out_row_d = '0;
                end else begin
                    out_row_d = out_row_q + RW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            out_row_d = '0;
        end
    end

    // Output decode from the next state so the enables come straight off flops
    always_comb begin
        clr_d       = (state_d == S_CLR);
        cnt_en_d    = (state_d == S_COUNT);
        act_en_d    = (state_d == S_ACT);
        reg_push_d  = (state_d == S_DRAIN);
        out_valid_d = (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // Registered enables and status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_q       <= 1'b0;
            cnt_en_q    <= 1'b0;
            act_en_q    <= 1'b0;
            reg_push_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            clr_q       <= clr_d;
            cnt_en_q    <= cnt_en_d;
            act_en_q    <= act_en_d;
            reg_push_q  <= reg_push_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign clr       = clr_q;
    assign cnt_en    = cnt_en_q;
    assign act_en    = act_en_q;
    assign reg_push  = reg_push_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign out_row   = out_row_q;
    assign shft_amt  = shft_amt_q;
    assign row_mask  = row_mask_q;

endmodule

// File: tb/tb_sc2bin_array_ctrl.sv
// tb/tb_sc2bin_array_ctrl.sv - self-checking bench for sc2bin_array_ctrl against a cycle-offset model
module tb_sc2bin_array_ctrl;

    localparam int ROW      = 3;
    localparam int LEN_W    = 10;
    localparam int MAX_SHFT = 4;
    localparam int ACT_LAT  = 1;
    localparam int SW       = $clog2(MAX_SHFT + 1);
    localparam int RW       = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int VW       = 7 + RW + SW + ROW;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] cfg_len;
    logic [SW-1:0]    cfg_shft;
    logic [ROW-1:0]   cfg_row_mask;
    logic             clr, cnt_en, act_en, reg_push, busy, out_valid, done;
    logic [SW-1:0]    shft_amt;
    logic [ROW-1:0]   row_mask;
    logic [RW-1:0]    out_row;

    sc2bin_array_ctrl #(
        .ROW(ROW), .LEN_W(LEN_W), .MAX_SHFT(MAX_SHFT), .ACT_LAT(ACT_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_len(cfg_len), .cfg_shft(cfg_shft), .cfg_row_mask(cfg_row_mask),
        .clr(clr), .cnt_en(cnt_en), .act_en(act_en), .reg_push(reg_push),
        .shft_amt(shft_amt), .row_mask(row_mask), .busy(busy),
        .out_valid(out_valid), .done(done), .out_row(out_row)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: a conversion is just "k cycles since the accepted start" with length m_len
    bit             m_act;
    int             m_k;
    int             m_len;
    logic [SW-1:0]  m_shft;
    logic [ROW-1:0] m_mask;

    wire [VW-1:0] dut_vec = {busy, clr, cnt_en, act_en, reg_push, out_valid, done,
                             out_row, shft_amt, row_mask};

    function automatic logic [VW-1:0] model_vec();
        int first_ov = 3 + m_len + ACT_LAT;
        int fin      = first_ov + ROW;
        logic b, c, cn, a, ov, d;
        int r = 0;
        b  = m_act;
        c  = m_act && (m_k == 1);
        cn = m_act && (m_k >= 2) && (m_k <= 1 + m_len);
        a  = m_act && (m_k == 2 + m_len);
        ov = m_act && (m_k >= first_ov) && (m_k < fin);
        d  = m_act && (m_k == fin);
        if (ov) r = m_k - first_ov;
        return {b, c, cn, a, ov, ov, d, RW'(r), m_shft, m_mask};
    endfunction

    task automatic model_reset();
        m_act  = 1'b0;
        m_k    = 0;
        m_len  = 0;
        m_shft = '0;
        m_mask = '0;
    endtask

    task automatic check(input string tag);
        logic [VW-1:0] exp_v;
        exp_v = model_vec();
        checks++;
        assert (dut_vec === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (k=%0d len=%0d)", tag, dut_vec, exp_v, m_k, m_len);
        end
    endtask

    // Check the current cycle, apply inputs, advance model and DUT by one clock
    task automatic step(input logic s, input logic ab, input string tag);
        check(tag);
        start = s;
        abort = ab;
        if (m_act && ab) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (s && !ab) begin
                m_act  = 1'b1;
                m_k    = 1;
                m_len  = int'(cfg_len);
                m_shft = (cfg_shft > SW'(MAX_SHFT)) ? SW'(MAX_SHFT) : cfg_shft;
                m_mask = cfg_row_mask;
            end
        end else begin
            m_k++;
            if (m_k > 3 + m_len + ACT_LAT + ROW) m_act = 1'b0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic scramble_cfg();
        cfg_len      = LEN_W'($urandom_range(0, 12));
        cfg_shft     = SW'($urandom_range(0, (1 << SW) - 1));
        cfg_row_mask = ROW'($urandom);
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        cfg_len      = '0;
        cfg_shft     = '0;
        cfg_row_mask = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state");
        reset_n = 1'b1;

        // Length 4, shift clamped, mask 101, cfg scrambled mid-run
        cfg_len = 4; cfg_shft = 7; cfg_row_mask = 3'b101;
        step(1'b1, 1'b0, "len4_start");
        for (int i = 0; i < 12; i++) begin
            scramble_cfg();
            step(1'b0, 1'b0, "len4_run");
        end

        // Zero length skips COUNT
        cfg_len = 0; cfg_shft = 2; cfg_row_mask = 3'b011;
        step(1'b1, 1'b0, "len0_start");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "len0_run");

        // Abort on the third COUNT cycle, then restart immediately
        cfg_len = 6; cfg_shft = 1; cfg_row_mask = 3'b110;
        step(1'b1, 1'b0, "abort_start");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "abort_pre");
        step(1'b0, 1'b1, "abort_count3");
        cfg_len = 1;
        step(1'b1, 1'b0, "abort_restart");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "start_while_busy");

        // Start together with abort in IDLE is ignored
        step(1'b1, 1'b1, "start_abort_idle");
        step(1'b0, 1'b0, "start_abort_idle_after");

        // Reset pulsed in the middle of DRAIN
        cfg_len = 2; cfg_shft = 3; cfg_row_mask = 3'b111;
        step(1'b1, 1'b0, "rst_start");
        while (m_k < 3 + m_len + ACT_LAT + 1) step(1'b0, 1'b0, "rst_pre");
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_async");
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("rst_held");
        reset_n = 1'b1;
        cfg_len = 3; cfg_shft = 4; cfg_row_mask = 3'b010;
        step(1'b1, 1'b0, "rst_first_start");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "rst_after_run");

        // Full-scale length must not wrap
        cfg_len = '1; cfg_shft = 5; cfg_row_mask = 3'b001;
        step(1'b1, 1'b0, "maxlen_start");
        for (int i = 0; i < 1100 && m_act; i++) step(1'b0, 1'b0, "maxlen_run");
        step(1'b0, 1'b0, "maxlen_idle");

        // Randomized starts, aborts and config churn
        for (int i = 0; i < 600; i++) begin
            logic s, ab;
            scramble_cfg();
            s  = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 40) == 0);
            step(s, ab, "random");
        end
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, "random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc2bin_array_ctrl.md
SC2BIN_ARRAY_CTRL -- requirements
Module: sc2bin_array_ctrl

Interface
REQ-001 SHALL have parameter ROW, default 3, the number of rows in the driven sc2bin array (ROW >= 1).
REQ-002 SHALL have parameter LEN_W, default 10, the width of the stream-length configuration.
REQ-003 SHALL have parameter MAX_SHFT, default 4, the maximum supported shift amount (MAX_SHFT >= 1).
REQ-004 SHALL have parameter ACT_LAT, default 1, the number of settle cycles after act_en (1 + SUBT_REG + RELU_REG + SHFT_REG of the array; ACT_LAT >= 1).
REQ-005 SHALL define SW = $clog2(MAX_SHFT+1) and RW = max(1,$clog2(ROW)).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  request one conversion; sampled only in IDLE.
REQ-009 abort  input  1  synchronous cancel of an in-flight conversion.
REQ-010 cfg_len  input  LEN_W  number of cnt_en cycles (stochastic stream length).
REQ-011 cfg_shft  input  SW  requested shift amount.
REQ-012 cfg_row_mask  input  ROW  rows enabled for this conversion.
REQ-013 clr  output  1  counter clear to array.
REQ-014 cnt_en  output  1  counter enable to array.
REQ-015 act_en  output  1  subtract/ReLU/shift enable to array.
REQ-016 reg_push  output  1  array output-register shift (1) vs. load (0).
REQ-017 shft_amt  output  SW  shift amount to array.
REQ-018 row_mask  output  ROW  row mask to array.
REQ-019 busy, out_valid, done  output  1 each  status: not IDLE; array bin_out holds a valid row; one-cycle completion pulse.
REQ-020 out_row  output  RW  row index currently presented on array bin_out.

Function
REQ-021 SHALL implement states IDLE, CLR, COUNT, ACT, SETTLE, DRAIN, DONE; busy = (state != IDLE).
REQ-022 In IDLE with start=1 and abort=0, SHALL latch cfg_len, min(cfg_shft,MAX_SHFT) into shft_amt and cfg_row_mask into row_mask, and go to CLR.
REQ-023 shft_amt and row_mask SHALL hold the latched values until the next accepted start; start outside IDLE SHALL be ignored.
REQ-024 CLR: clr=1 for exactly one cycle; next state is COUNT if latched len > 0, else ACT.
REQ-025 COUNT: cnt_en=1 for exactly len consecutive cycles (down-counter), then ACT; len = 2^LEN_W-1 SHALL not wrap.
REQ-026 ACT: act_en=1 for exactly one cycle, then SETTLE.
REQ-027 SETTLE: all enables 0, reg_push=0 for exactly ACT_LAT cycles, then DRAIN with out_row=0.
REQ-028 DRAIN: lasts exactly ROW cycles; out_valid=1, reg_push=1, out_row = 0,1,...,ROW-1 in successive cycles; then DONE.
REQ-029 DONE: done=1 for exactly one cycle, all other enables 0, reg_push=0; then IDLE.
REQ-030 reg_push SHALL be 1 only in DRAIN; clr, cnt_en, act_en, out_valid, done SHALL each be 0 outside their named state; at most one of clr/cnt_en/act_en high per cycle.
REQ-031 Latency: start accepted in cycle T gives clr at T+1, cnt_en T+2..T+1+L, act_en T+2+L, first out_valid T+3+L+ACT_LAT, done T+3+L+ACT_LAT+ROW.
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE next cycle with no done pulse; abort has priority over start in IDLE and over every transition.
REQ-033 Enables and status outputs SHALL be registered (glitch-free).

Reset
REQ-034 reset_n=0 SHALL immediately force IDLE and all outputs to 0 (row_mask=0, shft_amt=0, out_row=0), including mid-conversion; no done is issued.
REQ-035 After reset_n rises, the block SHALL accept start on the first rising edge.

Verification
REQ-036 ROW=3, ACT_LAT=1, start at cycle 0, cfg_len=4 -> clr@1, cnt_en@2-5, act_en@6, out_valid@8-10 with out_row 0,1,2, done@11, busy 1..11.
REQ-037 cfg_len=0 -> clr@1, act_en@2, no cnt_en, out_valid@4-6, done@7.
REQ-038 cfg_shft=7 with MAX_SHFT=4, cfg_row_mask=3'b101 -> shft_amt=4, row_mask=101 held through done; changing cfg_* mid-run has no effect.
REQ-039 abort asserted in COUNT cycle 3 -> IDLE next cycle, cnt_en drops, no out_valid, no done; start next cycle accepted normally.
REQ-040 reset_n pulsed low during DRAIN -> all outputs 0 asynchronously, no done; start while busy and start+abort in IDLE both ignored.
